// File: rtl/program_counter_unit_pkg.sv
// Shared definitions for the program counter unit:
// action selects and a width helper.
package program_counter_unit_pkg;

  localparam logic [2:0] ACT_HOLD   = 3'd0;
  localparam logic [2:0] ACT_INC    = 3'd1;
  localparam logic [2:0] ACT_BRANCH = 3'd2;
  localparam logic [2:0] ACT_JUMP   = 3'd3;
  localparam logic [2:0] ACT_CALL   = 3'd4;
  localparam logic [2:0] ACT_RET    = 3'd5;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/program_counter_unit_adder.sv
// Generate/propagate adder used for PC+STEP and PC+offset;
// the carry-out is not exposed since PC arithmetic wraps.
module nbit_CLA_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);

  // carry chain built from per-bit generate and propagate terms
  always_comb begin
    logic cy;
    cy  = cin;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | ((a[i] ^ b[i]) & cy);
    end
  end

endmodule

// File: rtl/program_counter_unit_return_stack.sv
// LIFO of return addresses; push when full and pop when
// empty are silently ignored, the parent flags the error.
module return_stack
  import program_counter_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    top_idx;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign top_idx = cnt_q - CW'(1);
  assign dout    = mem_q[AW'(top_idx)];

  // entry storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push && !full)
      mem_q[AW'(cnt_q)] <= din;
  end

  // occupancy count; push wins if both are requested
  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else if (push && !full)
      cnt_q <= cnt_q + CW'(1);
    else if (pop && !empty)
      cnt_q <= cnt_q - CW'(1);
  end

endmodule

// File: rtl/program_counter_unit.sv
// Program counter with step, jump, relative branch and
// call/return through an internal return-address stack.
module program_counter_unit
  import program_counter_unit_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int STEP         = 1,
  parameter int OFF_W        = 8,
  parameter int DEPTH        = 4,
  parameter int RESET_VECTOR = 0,
  localparam int CW = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             jump,
  input  logic             call,
  input  logic             ret,
  input  logic             branch,
  input  logic [WIDTH-1:0] target,
  input  logic [OFF_W-1:0] offset,
  output logic [WIDTH-1:0] pc,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             err
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             err_q, err_d;
  logic [2:0]       act;
  logic             push, pop;
  logic [WIDTH-1:0] inc_sum, br_sum, off_ext, top_w;
  logic [CW-1:0]    count;
  logic             room, avail;
  logic             s_j, s_c, s_r, s_b;

  assign off_ext = WIDTH'($signed(offset));
  assign room    = (count < CW'(DEPTH));
  assign avail   = (count != '0);

  nbit_CLA_full_adder #(.WIDTH(WIDTH)) u_inc (
    .a   (pc_q),
    .b   (WIDTH'(STEP)),
    .cin (1'b0),
    .sum (inc_sum)
  );

  nbit_CLA_full_adder #(.WIDTH(WIDTH)) u_br (
    .a   (pc_q),
    .b   (off_ext),
    .cin (1'b0),
    .sum (br_sum)
  );

  return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stk (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (inc_sum),
    .dout  (top_w),
    .count (count),
    .full  (stack_full),
    .empty (stack_empty)
  );

  // priority-mask requests so at most one select is live
  always_comb begin
    s_j = jump;
    s_c = call & ~jump;
    s_r = ret & ~call & ~jump;
    s_b = branch & ~ret & ~call & ~jump;
    act = ACT_HOLD;
    if (en) begin
      unique case (1'b1)
        s_j:     act = ACT_JUMP;
        s_c:     act = ACT_CALL;
        s_r:     act = ACT_RET;
        s_b:     act = ACT_BRANCH;
        default: act = ACT_INC;
      endcase
    end
  end

  // next PC, stack strobes and error for the chosen action
  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    push  = 1'b0;
    pop   = 1'b0;
    case (act)
      ACT_JUMP: pc_d = target;
      ACT_CALL: begin
        pc_d = target;
        if (room) push = 1'b1;
        else      err_d = 1'b1;
      end
      ACT_RET: begin
        if (avail) begin
          pc_d = top_w;
          pop  = 1'b1;
        end else begin
          pc_d  = inc_sum;
          err_d = 1'b1;
        end
      end
      ACT_BRANCH: pc_d = br_sum;
      ACT_INC:    pc_d = inc_sum;
      default:    pc_d = pc_q;
    endcase
  end

  // PC and sticky error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= WIDTH'(RESET_VECTOR);
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign pc  = pc_q;
  assign err = err_q;

endmodule
